// File: rtl/icache_pkg.sv
// Shared types and default constants for the instruction-cache line responder.
// State encoding lives here so the controller and any observers agree on it.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } rsp_state_e;

  localparam int unsigned DEF_ADDR_WIDTH     = 16;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_WORDS_PER_LINE = 4;
  localparam int unsigned DEF_MEM_DEPTH      = 1024;
  localparam int unsigned DEF_LATENCY        = 4;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_line_array.sv
// Backing word store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so preloaded data survives a reset.
module mem_line_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/mem_line_responder.sv
// Line-fill responder: IDLE -> WAIT (fixed latency) -> BURST of one line.
// Define MEM_RESP_CRITICAL_WORD_FIRST_EN to start bursts at the missed word.
module mem_line_responder
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int unsigned MEM_DEPTH      = DEF_MEM_DEPTH,
  parameter int unsigned LATENCY        = DEF_LATENCY
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic                              i_halt,
  input  logic                              i_req_valid,
  input  logic [ADDR_WIDTH-1:0]             i_req_addr,
  output logic                              o_req_ready,
  output logic                              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]             o_rsp_data,
  output logic [$clog2(WORDS_PER_LINE)-1:0] o_rsp_word_idx,
  output logic                              o_rsp_last,
  input  logic                              i_rsp_ready,
  output logic                              o_busy,
  input  logic                              i_wr_en,
  input  logic [ADDR_WIDTH-1:0]             i_wr_addr,
  input  logic [DATA_WIDTH-1:0]             i_wr_data
);

  localparam int unsigned OFFW   = $clog2(WORDS_PER_LINE);
  localparam int unsigned LINEW  = ADDR_WIDTH - OFFW;
  localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W  = cnt_width(LATENCY);

  rsp_state_e state_q, state_d;

  logic [LINEW-1:0] line_q, line_d;
  logic [OFFW-1:0]  idx_q, idx_d;
  logic [OFFW-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                  accept;
  logic                  beat_fire;
  logic                  beat_last;
  logic                  wr_fire;
  logic [OFFW-1:0]       start_off;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  assign o_req_ready = (state_q == ST_IDLE) & ~i_halt;
  assign accept      = i_req_valid & o_req_ready;
  assign beat_fire   = (state_q == ST_BURST) & i_rsp_ready & ~i_halt;
  assign beat_last   = (beat_q == '1);
  assign wr_fire     = i_wr_en & ~i_halt & (state_q == ST_IDLE);
  assign rd_addr     = {line_q, idx_q};

`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
  assign start_off = i_req_addr[OFFW-1:0];
`else
  logic unused_off;
  assign unused_off = ^i_req_addr[OFFW-1:0];
  assign start_off  = '0;
`endif

  generate
    if (ADDR_WIDTH > MEM_AW) begin : g_hi
      // Addresses alias modulo MEM_DEPTH; upper bits are dropped.
      logic unused_hi;
      assign unused_hi = ^{rd_addr[ADDR_WIDTH-1:MEM_AW],
                           i_wr_addr[ADDR_WIDTH-1:MEM_AW]};
    end
  endgenerate

  mem_line_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (wr_fire),
    .i_waddr (i_wr_addr[MEM_AW-1:0]),
    .i_wdata (i_wr_data),
    .i_raddr (rd_addr[MEM_AW-1:0]),
    .o_rdata (rd_data)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!i_halt && cnt_q == '0) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (beat_fire && beat_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      line_q <= '0;
      idx_q  <= '0;
      beat_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      idx_q  <= idx_d;
      beat_q <= beat_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    line_d = line_q;
    idx_d  = idx_q;
    beat_d = beat_q;
    cnt_d  = cnt_q;
    if (accept) begin
      line_d = i_req_addr[ADDR_WIDTH-1:OFFW];
      idx_d  = start_off;
      beat_d = '0;
      cnt_d  = CNT_W'(LATENCY - 1);
    end
    if (state_q == ST_WAIT && !i_halt && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (beat_fire) begin
      idx_d  = idx_q + 1'b1;
      beat_d = beat_q + 1'b1;
    end
  end

  always_comb begin
    o_busy         = (state_q != ST_IDLE);
    o_rsp_valid    = 1'b0;
    o_rsp_last     = 1'b0;
    o_rsp_word_idx = '0;
    o_rsp_data     = '0;
    if (state_q == ST_BURST) begin
      o_rsp_valid    = 1'b1;
      o_rsp_last     = beat_last;
      o_rsp_word_idx = idx_q;
      o_rsp_data     = rd_data;
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: random fills against a word-array
// model; a negedge monitor pops expected beats as the DUT presents them.
module tb_mem_line_responder;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int WPL = 4;
  localparam int MD  = 1024;
  localparam int LAT = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
    bit            last;
  } beat_t;

  logic          clk = 0;
  logic          arst_n = 0;
  logic          i_halt = 0;
  logic          i_req_valid = 0;
  logic [AW-1:0] i_req_addr = '0;
  logic          o_req_ready;
  logic          o_rsp_valid;
  logic [DW-1:0] o_rsp_data;
  logic [1:0]    o_rsp_word_idx;
  logic          o_rsp_last;
  logic          i_rsp_ready = 0;
  logic          o_busy;
  logic          i_wr_en = 0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;

  mem_line_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL),
    .MEM_DEPTH(MD), .LATENCY(LAT)
  ) dut (
    .clk(clk), .arst_n(arst_n), .i_halt(i_halt),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid),
    .o_rsp_data(o_rsp_data), .o_rsp_word_idx(o_rsp_word_idx),
    .o_rsp_last(o_rsp_last), .i_rsp_ready(i_rsp_ready),
    .o_busy(o_busy), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model_mem [MD];
  beat_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  active = 0;
  bit  first_pending = 0;
  int  exp_first = 0;
  int  seen = 0;
  int  stalls = 0;
  int  burst_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: everything the DUT shows mid-cycle is checked against the model.
  always @(negedge clk) begin
    if (arst_n) begin
      chk("req_ready", longint'(o_req_ready), longint'(!active && !i_halt));
      chk("busy", longint'(o_busy), longint'(active));
      if (o_rsp_valid) begin
        if (first_pending) begin
          chk("first_beat_cycle", cyc, exp_first);
          first_pending = 0;
        end
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          chk("rsp_data", o_rsp_data, sb[0].data);
          chk("rsp_idx", o_rsp_word_idx, sb[0].idx);
          chk("rsp_last", o_rsp_last, sb[0].last);
          if (i_rsp_ready && !i_halt) begin
            if (sb[0].last) begin
              burst_len = seen + 1;
              chk("burst_len", burst_len, WPL + stalls);
              active = 0;
            end
            void'(sb.pop_front());
          end else begin
            stalls++;
          end
        end
        seen++;
      end
    end
  end

  task automatic write_word(input int a, input logic [DW-1:0] d);
    i_wr_en = 1; i_wr_addr = AW'(a); i_wr_data = d;
    @(posedge clk); #1;
    model_mem[a % MD] = d;
    i_wr_en = 0;
  endtask

  // mode 0: random ready/halt/spurious traffic, 1: ready held, 2: 3-cycle stall
  task automatic fill(input int a, input int hw, input int mode,
                      input bit do_wr, input int wa, input logic [DW-1:0] wd);
    int base, start, n;
    i_req_valid = 1; i_req_addr = AW'(a);
    i_wr_en = do_wr; i_wr_addr = AW'(wa); i_wr_data = wd;
    @(posedge clk); #1;
    i_req_valid = 0; i_wr_en = 0;
    if (do_wr) model_mem[wa % MD] = wd;
    base = a & ~(WPL - 1);
`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    start = a % WPL;
`else
    start = 0;
`endif
    for (int k = 0; k < WPL; k++) begin
      beat_t b;
      b.idx  = (start + k) % WPL;
      b.data = model_mem[(base + b.idx) % MD];
      b.last = (k == WPL - 1);
      sb.push_back(b);
    end
    seen = 0; stalls = 0;
    exp_first = cyc + LAT + hw;
    first_pending = 1;
    active = 1;
    if (hw > 0) begin
      @(posedge clk); #1;
      i_halt = 1;
      repeat (hw) @(posedge clk);
      #1 i_halt = 0;
    end
    n = 0;
    while (active && n < 300) begin
      case (mode)
        0: begin
          i_rsp_ready = ($urandom % 3) != 0;
          i_halt      = (seen > 0) && ($urandom % 5 == 0);
          i_req_valid = ($urandom % 3 == 0);
          i_req_addr  = AW'($urandom);
          i_wr_en     = ($urandom % 3 == 0);
          i_wr_addr   = AW'($urandom % MD);
          i_wr_data   = $urandom;
        end
        1: i_rsp_ready = 1;
        default: i_rsp_ready = (seen >= 3);
      endcase
      @(posedge clk); #1;
      n++;
    end
    i_rsp_ready = 0; i_halt = 0; i_req_valid = 0; i_wr_en = 0;
    if (n >= 300) begin
      chk("fill_timeout", n, 0);
      sb.delete(); active = 0; first_pending = 0;
    end
    if (mode == 2) chk("stalled_burst_len", burst_len, 7);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, o_rsp_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_last"}, o_rsp_last, 0);
    chk({tag, "_idx"}, o_rsp_word_idx, 0);
    chk({tag, "_data"}, o_rsp_data, 0);
    chk({tag, "_ready"}, o_req_ready, !i_halt);
  endtask

  initial begin
    #2;
    reset_checks("rst");
    i_halt = 1; #1;
    chk("rst_ready_halt", o_req_ready, 0);
    i_halt = 0;
    @(negedge clk); arst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < MD; i++) write_word(i, $urandom);
    for (int i = 0; i < 4; i++) write_word('h40 + i, 32'hA0 + i);

    // Write attempted under halt must be dropped.
    i_halt = 1; i_wr_en = 1; i_wr_addr = 'h41; i_wr_data = 32'hDEAD;
    @(posedge clk); #1;
    i_halt = 0; i_wr_en = 0;

    fill('h42, 0, 1, 0, 0, 0);
    fill('h42, 0, 2, 0, 0, 0);
    fill('h42, 5, 1, 0, 0, 0);
    fill($urandom, 0, 0, 0, 0, 0);
    fill('h41, 0, 1, 0, 0, 0);
    fill('h7FE, 0, 1, 0, 0, 0);
    fill('h43, 0, 1, 1, 'h42, 32'h1234_5678);

    // Abort a fill during beat 2 with reset.
    i_req_valid = 1; i_req_addr = 'h42;
    @(posedge clk); #1;
    i_req_valid = 0;
    active = 1;
    for (int k = 0; k < WPL; k++) begin
      beat_t b;
`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
      b.idx = (2 + k) % WPL;
`else
      b.idx = k;
`endif
      b.data = model_mem['h40 + b.idx];
      b.last = (k == WPL - 1);
      sb.push_back(b);
    end
    seen = 0; stalls = 0; first_pending = 1; exp_first = cyc + LAT;
    i_rsp_ready = 1;
    for (int n = 0; n < 50 && seen < 1; n++) begin
      @(posedge clk); #1;
    end
    chk("abort_reached_beat2", seen, 1);
    chk("abort_valid_before", o_rsp_valid, 1);
    arst_n = 0; #1;
    reset_checks("abort");
    sb.delete(); active = 0; first_pending = 0; i_rsp_ready = 0;
    @(negedge clk); arst_n = 1;
    @(posedge clk); #1;
    fill('h42, 0, 1, 0, 0, 0);

    for (int t = 0; t < 24; t++) begin
      if ($urandom % 2 == 0) write_word($urandom % MD, $urandom);
      fill($urandom, $urandom % 4, ($urandom % 2 == 0) ? 0 : 2 - ($urandom % 2), 0, 0, 0);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
